// File: rtl/fj_pkg.sv
// fj_pkg: shared types and defaults for the fork/join sequencer.
//   join_mode_e      - join policy latched with each fork
//   fj_state_e       - sequencer FSM states
//   FJ_*_DEF         - default parameter values
//   fj_decode_mode() - maps the raw 2-bit join_mode input to a policy
package fj_pkg;

    typedef enum logic [1:0] {
        JOIN_ALL,
        JOIN_ANY,
        JOIN_NONE
    } join_mode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_REPORT,
        S_DRAIN
    } fj_state_e;

    localparam int unsigned FJ_N_BRANCH_DEF = 2;
    localparam int unsigned FJ_CNT_W_DEF    = 16;
    localparam int unsigned FJ_TMO_CYC_DEF  = 1000;

    // Reserved encoding 3 falls back to ALL. ANY with an empty launch mask
    // could never see a completion, so it degrades to ALL and fires at once.
    function automatic join_mode_e fj_decode_mode(input logic [1:0] raw,
                                                  input logic       none_enabled);
        join_mode_e m;
        case (raw)
            2'd1:    m = none_enabled ? JOIN_ALL : JOIN_ANY;
            2'd2:    m = JOIN_NONE;
            default: m = JOIN_ALL;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/fj_branch_tracker.sv
// fj_branch_tracker: per-branch pending/completed register bank.
//   clk_i, rst_i       - clock, async active-high reset
//   load_i             - fork accepted: pending <= load_mask_i, completed <= 0
//   load_mask_i        - branches being launched
//   clear_i            - drop all pending bits (forced join)
//   done_i             - one-cycle completion pulses from the branches
//   pending_o          - registered pending mask
//   completed_nxt_o    - completed mask including this cycle's done pulses
//   all_done_o         - nothing left pending after this cycle's pulses
//   any_done_o         - at least one branch completed, counting this cycle
//   spurious_o         - (FJ_TIMEOUT_EN only) done pulse on a non-pending bit
import fj_pkg::*;

module fj_branch_tracker #(
    parameter int unsigned N_BRANCH = FJ_N_BRANCH_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic [N_BRANCH-1:0] load_mask_i,
    input  logic                clear_i,
    input  logic [N_BRANCH-1:0] done_i,
    output logic [N_BRANCH-1:0] pending_o,
    output logic [N_BRANCH-1:0] completed_nxt_o,
    output logic                all_done_o,
`ifdef FJ_TIMEOUT_EN
    output logic                spurious_o,
`endif
    output logic                any_done_o
);

    logic [N_BRANCH-1:0] pending_q, pending_d;
    logic [N_BRANCH-1:0] completed_q, completed_d;
    logic [N_BRANCH-1:0] pend_abs, comp_abs;

    // Only pulses on pending bits count; anything else is ignored.
    always_comb begin
        pend_abs = pending_q & ~done_i;
        comp_abs = completed_q | (done_i & pending_q);
        if (load_i) begin
            pending_d   = load_mask_i;
            completed_d = '0;
        end else begin
            pending_d   = clear_i ? '0 : pend_abs;
            completed_d = comp_abs;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q   <= '0;
            completed_q <= '0;
        end else begin
            pending_q   <= pending_d;
            completed_q <= completed_d;
        end
    end

    assign pending_o       = pending_q;
    assign completed_nxt_o = comp_abs;
    assign all_done_o      = ~|pend_abs;
    assign any_done_o      = |comp_abs;
`ifdef FJ_TIMEOUT_EN
    assign spurious_o      = |(done_i & ~pending_q);
`endif

endmodule

// File: rtl/fork_join_ctrl.sv
// fork_join_ctrl: fork/join sequencer. Launches up to N_BRANCH branch
// engines with one-cycle start pulses and reports completion under an
// ALL / ANY / NONE join policy.
//   clk, rst       - clock, async active-high reset
//   start_valid/start_ready - fork request handshake (ready only in IDLE)
//   join_mode      - 0=ALL 1=ANY 2=NONE 3=ALL, sampled with start
//   branch_en      - branches to launch, sampled with start
//   branch_start   - one-cycle launch pulse per enabled branch
//   branch_done    - one-cycle completion pulse per branch
//   done_valid/done_ready - completion handshake, held until accepted
//   done_mask      - branches complete when the join fired
//   elapsed        - cycles from start accept to join fire (saturating)
//   busy           - launched branches still outstanding
//   timeout        - (FJ_TIMEOUT_EN) join was forced after TMO_CYC cycles
//   err_spurious   - (FJ_TIMEOUT_EN) sticky: done pulse on a non-pending bit
// Optional feature macro: FJ_TIMEOUT_EN.
import fj_pkg::*;

module fork_join_ctrl #(
    parameter int unsigned N_BRANCH = FJ_N_BRANCH_DEF,
    parameter int unsigned CNT_W    = FJ_CNT_W_DEF,
    parameter int unsigned TMO_CYC  = FJ_TMO_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [1:0]          join_mode,
    input  logic [N_BRANCH-1:0] branch_en,
    output logic [N_BRANCH-1:0] branch_start,
    input  logic [N_BRANCH-1:0] branch_done,
    output logic                done_valid,
    input  logic                done_ready,
    output logic [N_BRANCH-1:0] done_mask,
    output logic [CNT_W-1:0]    elapsed,
`ifdef FJ_TIMEOUT_EN
    output logic                timeout,
    output logic                err_spurious,
`endif
    output logic                busy
);

    fj_state_e           state_q, state_d;
    join_mode_e          mode_q, mode_d;
    logic [CNT_W-1:0]    elapsed_q, elapsed_d, elapsed_inc;
    logic [N_BRANCH-1:0] done_mask_q, done_mask_d;

    logic                trk_load, trk_clear;
    logic [N_BRANCH-1:0] trk_pending, trk_comp_nxt;
    logic                trk_all_done, trk_any_done;
    logic                join_fire;

`ifdef FJ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TMO_CYC);
    logic timeout_q, timeout_d;
    logic err_q;
    logic trk_spurious;
`endif

    fj_branch_tracker #(
        .N_BRANCH (N_BRANCH)
    ) u_tracker (
        .clk_i           (clk),
        .rst_i           (rst),
        .load_i          (trk_load),
        .load_mask_i     (branch_en),
        .clear_i         (trk_clear),
        .done_i          (branch_done),
        .pending_o       (trk_pending),
        .completed_nxt_o (trk_comp_nxt),
        .all_done_o      (trk_all_done),
`ifdef FJ_TIMEOUT_EN
        .spurious_o      (trk_spurious),
`endif
        .any_done_o      (trk_any_done)
    );

    assign elapsed_inc = (&elapsed_q) ? elapsed_q : elapsed_q + CNT_W'(1);
    assign join_fire   = (mode_q == JOIN_ANY) ? trk_any_done : trk_all_done;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        elapsed_d   = elapsed_q;
        done_mask_d = done_mask_q;
        trk_load    = 1'b0;
        trk_clear   = 1'b0;
`ifdef FJ_TIMEOUT_EN
        timeout_d   = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    state_d     = S_LAUNCH;
                    mode_d      = fj_decode_mode(join_mode, branch_en == '0);
                    elapsed_d   = '0;
                    done_mask_d = '0;
                    trk_load    = 1'b1;
                end
            end
            S_LAUNCH: begin
                // NONE reports immediately with elapsed held at zero; the
                // other policies count the launch cycle as elapsed time.
                if (mode_q == JOIN_NONE) begin
                    state_d = S_REPORT;
                end else begin
                    state_d   = S_WAIT;
                    elapsed_d = elapsed_inc;
                end
            end
            S_WAIT: begin
                elapsed_d = elapsed_inc;
                if (join_fire) begin
                    done_mask_d = trk_comp_nxt;
                    state_d     = S_REPORT;
                end
`ifdef FJ_TIMEOUT_EN
                else if (elapsed_inc == TMO_LIM) begin
                    done_mask_d = trk_comp_nxt;
                    timeout_d   = 1'b1;
                    trk_clear   = 1'b1;
                    state_d     = S_REPORT;
                end
`endif
            end
            S_REPORT: begin
                if (done_ready) begin
                    state_d = trk_all_done ? S_IDLE : S_DRAIN;
`ifdef FJ_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            S_DRAIN: begin
                if (trk_all_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= JOIN_ALL;
            elapsed_q   <= '0;
            done_mask_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            elapsed_q   <= elapsed_d;
            done_mask_q <= done_mask_d;
        end
    end

`ifdef FJ_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
            err_q     <= err_q | trk_spurious;
        end
    end

    assign timeout      = timeout_q;
    assign err_spurious = err_q;
`endif

    assign start_ready  = (state_q == S_IDLE);
    assign done_valid   = (state_q == S_REPORT);
    assign branch_start = (state_q == S_LAUNCH) ? trk_pending : '0;
    assign done_mask    = done_mask_q;
    assign elapsed      = elapsed_q;
    assign busy         = (state_q != S_IDLE) && (trk_pending != '0);

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Bench for fork_join_ctrl: directed forks with hand-computed join results
// queued at launch and checked by an independent completion monitor.
module tb_fork_join_ctrl;

    localparam int NB = 2;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic [1:0]    join_mode = 2'd0;
    logic [NB-1:0] branch_en = '0;
    logic [NB-1:0] branch_start;
    logic [NB-1:0] branch_done = '0;
    logic          done_valid;
    logic          done_ready = 1'b0;
    logic [NB-1:0] done_mask;
    logic [CW-1:0] elapsed;
    logic          busy;
`ifdef FJ_TIMEOUT_EN
    logic          timeout;
    logic          err_spurious;
`endif

    fork_join_ctrl #(
        .N_BRANCH (NB),
        .CNT_W    (CW),
`ifdef FJ_TIMEOUT_EN
        .TMO_CYC  (50)
`else
        .TMO_CYC  (1000)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .join_mode    (join_mode),
        .branch_en    (branch_en),
        .branch_start (branch_start),
        .branch_done  (branch_done),
        .done_valid   (done_valid),
        .done_ready   (done_ready),
        .done_mask    (done_mask),
        .elapsed      (elapsed),
`ifdef FJ_TIMEOUT_EN
        .timeout      (timeout),
        .err_spurious (err_spurious),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Edge counter: at each negedge it holds the index of the last posedge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [NB-1:0] mask;
        logic [CW-1:0] el;
        logic          busy;
        logic          tmo;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   acc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Completion monitor: pops one expectation per done_valid and accepts it.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_ready) begin
                done_ready = 1'b0;
            end else if (done_valid && !rst) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done_valid: got done_valid=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    check("fire_cycle", cyc, e.cyc);
                    check("done_mask", 32'(done_mask), 32'(e.mask));
                    check("elapsed", 32'(elapsed), 32'(e.el));
                    check("busy_at_report", 32'(busy), 32'(e.busy));
`ifdef FJ_TIMEOUT_EN
                    check("timeout", 32'(timeout), 32'(e.tmo));
`endif
                end
                done_ready = 1'b1;
            end
        end
    end

    task automatic launch(input logic [1:0] mode, input logic [NB-1:0] en,
                          input logic [NB-1:0] exp_start);
        check("start_ready_idle", 32'(start_ready), 32'd1);
        start_valid = 1'b1;
        join_mode   = mode;
        branch_en   = en;
        @(negedge clk);
        start_valid = 1'b0;
        join_mode   = 2'd0;
        branch_en   = '0;
        acc         = cyc;
        check("branch_start", 32'(branch_start), 32'(exp_start));
    endtask

    task automatic push(input int off, input logic [NB-1:0] mask, input int el,
                        input logic b, input logic tmo);
        exp_t e;
        e.cyc  = acc + off;
        e.mask = mask;
        e.el   = CW'(el);
        e.busy = b;
        e.tmo  = tmo;
        sbq.push_back(e);
    endtask

    task automatic run_to(input int off);
        while (cyc < acc + off) @(negedge clk);
    endtask

    task automatic pulse(input logic [NB-1:0] b);
        branch_done = b;
        @(negedge clk);
        branch_done = '0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (sbq.size() == 0 && start_ready && !done_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_return_idle: got pending=%0d start_ready=%0b expected empty/1",
                     name, sbq.size(), start_ready);
            sbq.delete();
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish within 200000 time units");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        repeat (3) @(negedge clk);
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_done_valid", 32'(done_valid), 32'd0);
        check("rst_branch_start", 32'(branch_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_elapsed", 32'(elapsed), 32'd0);
        check("rst_done_mask", 32'(done_mask), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ALL: dones at +20 and +30 -> fire at +31
        launch(2'd0, 2'b11, 2'b11);
        push(31, 2'b11, 31, 1'b0, 1'b0);
        run_to(20); pulse(2'b01);
        run_to(30); pulse(2'b10);
        wait_idle("all");

        // ANY: fire one cycle after branch 0, then drain until branch 1
        launch(2'd1, 2'b11, 2'b11);
        push(21, 2'b01, 21, 1'b1, 1'b0);
        run_to(20); pulse(2'b01);
        run_to(29);
        check("any_drain_start_ready", 32'(start_ready), 32'd0);
        check("any_drain_busy", 32'(busy), 32'd1);
        run_to(30); pulse(2'b10);
        check("any_drain_exit_start_ready", 32'(start_ready), 32'd1);
        check("any_drain_exit_busy", 32'(busy), 32'd0);
        wait_idle("any");

        // NONE: report right after the launch pulse, then drain
        launch(2'd2, 2'b11, 2'b11);
        push(1, 2'b00, 0, 1'b1, 1'b0);
        run_to(5); pulse(2'b01);
        run_to(8);
        check("none_drain_start_ready", 32'(start_ready), 32'd0);
        pulse(2'b10);
        check("none_drain_exit_start_ready", 32'(start_ready), 32'd1);
        wait_idle("none");

        // ANY with both dones in one cycle: full mask, no drain
        launch(2'd1, 2'b11, 2'b11);
        push(6, 2'b11, 6, 1'b0, 1'b0);
        run_to(5); pulse(2'b11);
        run_to(7);
        check("any_same_cycle_no_drain", 32'(start_ready), 32'd1);
        wait_idle("any_same");

        // Empty launch mask: ALL and ANY both fire immediately
        launch(2'd0, 2'b00, 2'b00);
        push(2, 2'b00, 2, 1'b0, 1'b0);
        wait_idle("all_empty");
        launch(2'd1, 2'b00, 2'b00);
        push(2, 2'b00, 2, 1'b0, 1'b0);
        wait_idle("any_empty");

        // Reserved mode 3 behaves as ALL
        launch(2'd3, 2'b11, 2'b11);
        push(7, 2'b11, 7, 1'b0, 1'b0);
        run_to(3); pulse(2'b01);
        run_to(6); pulse(2'b10);
        wait_idle("mode3");

        // Reset in WAIT, stale dones ignored, fresh fork on branch 0 only
        launch(2'd0, 2'b11, 2'b11);
        run_to(10);
        rst = 1'b1;
        #1;
        check("midrst_start_ready", 32'(start_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulse(2'b11);
        pulse(2'b10);
        @(negedge clk);
        check("midrst_no_done_valid", 32'(done_valid), 32'd0);
`ifdef FJ_TIMEOUT_EN
        check("err_spurious_sticky", 32'(err_spurious), 32'd1);
`endif
        launch(2'd0, 2'b01, 2'b01);
        push(13, 2'b01, 13, 1'b0, 1'b0);
        run_to(4); pulse(2'b10);
        run_to(12); pulse(2'b01);
        wait_idle("after_reset");

`ifdef FJ_TIMEOUT_EN
        // Branch 1 never completes: forced join at elapsed 50
        launch(2'd0, 2'b11, 2'b11);
        push(50, 2'b01, 50, 1'b0, 1'b1);
        run_to(5); pulse(2'b01);
        run_to(52);
        check("tmo_start_ready", 32'(start_ready), 32'd1);
        check("tmo_cleared", 32'(timeout), 32'd0);
        wait_idle("timeout");
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
